paddsb_serial: RTL and testbench
================================

# paddsb_serial

Nibble-serial saturating packed adder: executes the PADDSB operation on two 16-bit operands, one 4-bit lane per cycle, through a single 4-bit carry-lookahead add slice. Sits in the ALU stage next to the 4-bit add/sub slice. It feeds operand nibbles into the slice and consumes the slice's Sum and Ovfl. It trades three extra cycles for one adder slice instead of four, and delivers the packed result with a one-cycle done pulse.

## Interface
- No parameters; lane width 4 and lane count 4 are fixed.
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  16  operand A, four signed 4-bit lanes; lane 0 = a[3:0]. Sampled on the accepting edge only.
- b  input  16  operand B, same packing. Sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and sat_flags are valid.
- result  output  16  packed lane results; held until the next DONE.
- sat_flags  output  4  bit i set when lane i overflowed; held with result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN stays in RUN while lane counter < 3; RUN → DONE after lane 3.
  - DONE → RUN on start, otherwise DONE → IDLE.
- Accepting edge:
  - a and b load into internal shift registers.
  - Lane counter clears to 0.
  - Working accumulator and working flags clear.
- Each RUN cycle:
  - Slice inputs: A = a_sh[3:0], B = b_sh[3:0], Cin = 0.
  - Lane value = Sum, corrected per saturation rule.
  - Lane value shifts into working accumulator bits [15:12] (right-shift), so lane i lands at [4i+3:4i] after 4 shifts.
  - Ovfl shifts into working flags bit 3 the same way.
  - Operand registers shift right by 4; lane counter increments.
- Saturation rule, signed 4-bit: if Ovfl and A lane sign = 0, lane = 4'h7; if Ovfl and A lane sign = 1, lane = 4'h8; otherwise lane = Sum.
  - Ovfl = operand signs equal and Sum sign differs.
  - Cout, PG and GG of the slice are unused.
- On the edge entering DONE, result ← working accumulator and sat_flags ← working flags. At no other time do the outputs change, except reset.
- start while in RUN is ignored: no queueing, and operands are not resampled.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 16'h0000, sat_flags 4'b0000, lane counter 0.
- Start accepted at edge E0; lanes 0..3 computed at edges E1..E4.
- done high and result valid in the cycle after E4: latency 4 clocks from the accepting edge.
- busy high from E0 until E4 (exactly 4 cycles); low in DONE.
- Back-to-back: start high during DONE is accepted at the DONE→RUN edge, giving throughput of one op per 5 cycles. done stays a single-cycle pulse per op.
- rst asserted in any state:
  - Next state is IDLE; the in-flight op is discarded with no done pulse.
  - result and sat_flags clear to 0.
  - rst has priority over start on the same edge.
- The slice is combinational inside the RUN cycle; there is no additional pipeline register.

## Configuration
- Macro PADDSB_SAT_EN.
  - Defined: saturation rule applied as above.
  - Undefined: lane = Sum always (wrap-around modulo 16); sat_flags still reports Ovfl per lane.
- FSM, latency and handshake are identical in both builds.

## Test plan
- a=16'h1234, b=16'h1111, start one cycle → done 4 cycles later, result 16'h2345, sat_flags 4'b0000; busy high exactly 4 cycles.
- a=16'h7000, b=16'h1000 → result 16'h7000, sat_flags 4'b1000. Without PADDSB_SAT_EN → result 16'h8000, sat_flags 4'b1000.
- a=16'h0808, b=16'h0F0F → result 16'h0808, sat_flags 4'b0101. Without macro → 16'h0707, sat_flags 4'b0101.
- Hold start high continuously:
  - First op a=16'h1111, b=16'h2222 → result 16'h3333.
  - Inputs change during RUN and have no effect.
  - Second op accepted in the DONE cycle; its done occurs 5 cycles after the first done.
- Assert rst for one cycle at lane 2 of an op → busy 0 and result 16'h0000 next cycle; no done pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/paddsb_serial.sv
`default_nettype none
// ============================================================================
// Module   : paddsb_serial
// Function : Nibble-serial PADDSB. Two 16-bit operands are processed as four
//            signed 4-bit lanes, one lane per cycle, through one 4-bit
//            carry-lookahead add slice. A one-cycle done pulse presents the
//            packed result and the per-lane overflow flags.
// Config   : PADDSB_SAT_EN -- defined: overflowing lanes saturate to
//            4'h7 / 4'h8. Undefined: lanes wrap modulo 16. The flags,
//            FSM and timing are the same in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module paddsb_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  sat_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] a_sh_q, a_sh_d;
  logic [15:0] b_sh_q, b_sh_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  wflags_q, wflags_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  sat_flags_q, sat_flags_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  w_a_lane, w_b_lane;
  logic [3:0]  w_g, w_p;
  logic [3:0]  w_c;
  logic [3:0]  w_sum;
  logic        w_ovfl;
  logic [3:0]  w_lane_val;

  // 4-bit carry-lookahead slice on the low nibble of the operand shifters,
  // with the signed overflow detect and the lane correction on its output.
  always_comb begin
    w_a_lane = a_sh_q[3:0];
    w_b_lane = b_sh_q[3:0];
    w_g      = w_a_lane & w_b_lane;
    w_p      = w_a_lane ^ w_b_lane;
    w_c[0]   = 1'b0;
    w_c[1]   = w_g[0];
    w_c[2]   = w_g[1] | (w_p[1] & w_g[0]);
    w_c[3]   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]);
    w_sum    = w_p ^ w_c;
    w_ovfl   = (w_a_lane[3] == w_b_lane[3]) && (w_sum[3] != w_a_lane[3]);
`ifdef PADDSB_SAT_EN
    if (w_ovfl) begin
      w_lane_val = w_a_lane[3] ? 4'h8 : 4'h7;
    end else begin
      w_lane_val = w_sum;
    end
`else
    w_lane_val = w_sum;
`endif
  end

  // Next-state and datapath update: accept, shift one lane per RUN cycle,
  // publish the accumulated word on the edge that enters DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    wflags_d    = wflags_q;
    result_d    = result_q;
    sat_flags_d = sat_flags_q;
    done_d      = 1'b0;

    case (state_q)
      RUN: begin
        a_sh_d   = {4'h0, a_sh_q[15:4]};
        b_sh_d   = {4'h0, b_sh_q[15:4]};
        acc_d    = {w_lane_val, acc_q[15:4]};
        wflags_d = {w_ovfl, wflags_q[3:1]};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d     = DONE;
          result_d    = {w_lane_val, acc_q[15:4]};
          sat_flags_d = {w_ovfl, wflags_q[3:1]};
          done_d      = 1'b1;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          cnt_d    = 2'd0;
          acc_d    = 16'h0000;
          wflags_d = 4'b0000;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      a_sh_q      <= 16'h0000;
      b_sh_q      <= 16'h0000;
      acc_q       <= 16'h0000;
      wflags_q    <= 4'b0000;
      result_q    <= 16'h0000;
      sat_flags_q <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      wflags_q    <= wflags_d;
      result_q    <= result_d;
      sat_flags_q <= sat_flags_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign sat_flags = sat_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_paddsb_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddsb_serial
// Function : Self-checking bench for paddsb_serial. Directed vector table
//            plus hand-written back-to-back and mid-op reset sequences.
//            Expected values follow the PADDSB_SAT_EN build setting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddsb_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  sat_flags;

  int n_checks;
  int n_pass;

  paddsb_serial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sat_flags (sat_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, then follow it to done, checking latency, busy span,
  // the result word, the flags and that done falls after one cycle.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] er, input logic [3:0] ef);
    int lat;
    int busy_cycles;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);                 // accepting edge E0
    #1;
    start = 1'b0;
    a = ~va;                        // operands must not be resampled
    b = ~vb;
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cycles++;
    end
    check("latency", lat, 4);
    check("busy_cycles", busy_cycles, 4);
    check("result", {16'h0, result}, {16'h0, er});
    check("sat_flags", {28'h0, sat_flags}, {28'h0, ef});
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'h0, done}, 32'h0);
  endtask

  initial begin
    int lat;
    int seen_done;
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;

`ifdef PADDSB_SAT_EN
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 4'b0000};
    vecs[1] = '{16'h7000, 16'h1000, 16'h7000, 4'b1000};
    vecs[2] = '{16'h0808, 16'h0F0F, 16'h0808, 4'b0101};
    vecs[3] = '{16'h9999, 16'h9999, 16'h8888, 4'b1111};
`else
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 4'b0000};
    vecs[1] = '{16'h7000, 16'h1000, 16'h8000, 4'b1000};
    vecs[2] = '{16'h0808, 16'h0F0F, 16'h0707, 4'b0101};
    vecs[3] = '{16'h9999, 16'h9999, 16'h2222, 4'b1111};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_result", {16'h0, result}, 32'h0);
    check("reset_flags", {28'h0, sat_flags}, 32'h0);

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_res, vecs[i].exp_flags);
      repeat (2) @(posedge clk);
    end

    // Back-to-back with start held high
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    lat = 0;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_first_latency", lat, 4);
    check("b2b_first_result", {16'h0, result}, 32'h3333);
    check("b2b_busy_in_done", {31'h0, busy}, 32'h0);
    a = 16'h1234;                   // sampled at the DONE->RUN edge
    b = 16'h1111;
    @(posedge clk);
    #1;
    a = 16'h7777;
    b = 16'h7777;
    lat = 1;
    check("b2b_reaccept_busy", {31'h0, busy}, 32'h1);
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("b2b_done_spacing", lat, 5);
    check("b2b_second_result", {16'h0, result}, 32'h2345);
    repeat (3) @(posedge clk);

    // Reset during lane 2
    @(negedge clk);
    a = 16'h1111;
    b = 16'h1111;
    start = 1'b1;
    @(posedge clk);                 // E0
    #1;
    start = 1'b0;
    @(posedge clk);                 // E1 lane 0
    @(posedge clk);                 // E2 lane 1
    #1;
    rst = 1'b1;
    @(posedge clk);                 // E3 would compute lane 2
    #1;
    rst = 1'b0;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_result", {16'h0, result}, 32'h0);
    check("midrst_flags", {28'h0, sat_flags}, 32'h0);
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    check("midrst_no_done", seen_done, 0);
    run_op(16'h1234, 16'h1111, 16'h2345, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
